// File: rtl/ofm_pack_fifo.sv
// ofm_pack_fifo: buffers 128-bit result vectors and streams each one as four 32-bit write beats.
// Optional feature macro OFM_RELU_EN: negative int8 lanes are clamped to zero as vectors enter the FIFO.
module ofm_pack_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [15:0]            base_addr_i,
    input  logic [15:0]            num_vec_i,
    input  logic                   valid_i,
    input  logic [127:0]           data_i,
    output logic                   wr_valid_o,
    input  logic                   wr_ready_i,
    output logic [15:0]            wr_addr_o,
    output logic [31:0]            wr_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [127:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]  level;
    logic [17:0]  beat_cnt;
    logic [15:0]  in_cnt;
    logic [15:0]  num_vec;
    logic [127:0] push_data;
    logic [127:0] head;
    logic         transfer;
    logic         pop;
    logic         last_beat;
    logic         full;
    logic         want;
    logic         push;
    logic         drop;

`ifdef OFM_RELU_EN
    always_comb begin
        push_data = data_i;
        for (int unsigned i = 0; i < 16; i++) begin
            if (data_i[8*i+7]) push_data[8*i +: 8] = '0;
        end
    end
`else
    always_comb begin
        push_data = data_i;
    end
`endif

    // beat_cnt[1:0] doubles as the lane-group index within the head vector
    always_comb begin
        transfer  = wr_valid_o & wr_ready_i;
        pop       = transfer && (beat_cnt[1:0] == 2'd3);
        last_beat = transfer && (beat_cnt == ({num_vec, 2'b00} - 18'd1));
        full      = (level == FULL_LEVEL);
        want      = (state == RUN) && valid_i && (in_cnt < num_vec);
        push      = want && (!full || pop);
        drop      = want && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = (num_vec_i == '0) ? DONE : RUN;
            RUN:     if (last_beat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        head       = mem[rd_ptr];
        wr_valid_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        wr_data_o  = '0;
        case (state)
            RUN: begin
                busy_o     = 1'b1;
                wr_valid_o = (level != '0);
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
        if (wr_valid_o) begin
            case (beat_cnt[1:0])
                2'd0:    wr_data_o = head[31:0];
                2'd1:    wr_data_o = head[63:32];
                2'd2:    wr_data_o = head[95:64];
                default: wr_data_o = head[127:96];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            beat_cnt   <= '0;
            in_cnt     <= '0;
            num_vec    <= '0;
            wr_addr_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                wr_addr_o  <= base_addr_i;
                num_vec    <= num_vec_i;
                in_cnt     <= '0;
                beat_cnt   <= '0;
                overflow_o <= 1'b0;
            end
            if (transfer) begin
                wr_addr_o <= wr_addr_o + 16'd1;
                beat_cnt  <= beat_cnt + 18'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                in_cnt <= in_cnt + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow_o <= 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            // Leaving DONE flushes anything left so the next frame starts empty
            if (state == DONE) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                beat_cnt <= '0;
            end
        end
    end

    assign level_o = level;

endmodule
